// File: rtl/hms_pkg.sv
// Shared types and wrap limits for the hours/minutes/seconds BCD clock.
package hms_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_t;

  localparam bcd_t SEC_U_MAX        = 4'd9;
  localparam bcd_t SEC_T_MAX        = 4'd5;
  localparam bcd_t MIN_U_MAX        = 4'd9;
  localparam bcd_t MIN_T_MAX        = 4'd5;
  localparam bcd_t HOUR_U_MAX       = 4'd9;
  localparam bcd_t HOUR_U_MAX_24_HI = 4'd3;  // units limit once tens reach 2 (23)
  localparam bcd_t HOUR_T_MAX_24    = 4'd2;
  localparam bcd_t HOUR_T_MAX_12    = 4'd1;

  function automatic logic [6:0] bcd2_to_bin(input bcd_t tens, input bcd_t units);
    return ({3'b000, tens} * 7'd10) + {3'b000, units};
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: counts on enable up to a programmable max, then wraps and carries.
module bcd_digit_counter
  import hms_pkg::*;
#(
  parameter bcd_t RST_VAL = 4'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  bcd_t max,
  input  logic clear,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t digit,
  output logic carry
);

  assign carry = en && (digit == max);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= RST_VAL;
    end else if (load) begin
      digit <= load_val;
    end else if (clear) begin
      digit <= '0;
    end else if (en) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/hms_counter.sv
// Time-of-day counter (24h or 12h+PM) with a run/set mode FSM.
// Optional alarm compare is built only when HMS_ALARM_EN is defined.
//   state    | meaning
//   MODE_RUN | seconds advance on hms_tick, carries ripple to hours
//   MODE_SET | seconds held at 00, inc pulses adjust minutes/hours
module hms_counter
  import hms_pkg::*;
#(
  parameter int H24 = 1
) (
  input  logic       hms_clock,
  input  logic       hms_reset,
  input  logic       hms_tick,
  input  logic       hms_set_mode,
  input  logic       hms_inc_min,
  input  logic       hms_inc_hour,
  output logic [3:0] hms_sec_u,
  output logic [3:0] hms_sec_t,
  output logic [3:0] hms_min_u,
  output logic [3:0] hms_min_t,
  output logic [3:0] hms_hour_u,
  output logic [3:0] hms_hour_t,
  output logic       hms_pm,
  output logic       hms_day_pulse
`ifdef HMS_ALARM_EN
  ,
  input  logic [4:0] hms_alarm_hour,
  input  logic [5:0] hms_alarm_min,
  output logic       hms_alarm
`endif
);

  mode_t mode, mode_next;
  logic  run_tick, sec_clear, set_inc_min, set_inc_hour;

  always_ff @(posedge hms_clock) begin
    if (hms_reset) mode <= MODE_RUN;
    else           mode <= mode_next;
  end

  always_comb begin
    mode_next    = mode;
    run_tick     = 1'b0;
    sec_clear    = 1'b0;
    set_inc_min  = 1'b0;
    set_inc_hour = 1'b0;
    case (mode)
      MODE_RUN: begin
        if (hms_set_mode) begin
          mode_next = MODE_SET;
          sec_clear = 1'b1;
        end else begin
          run_tick = hms_tick;
        end
      end
      MODE_SET: begin
        sec_clear    = 1'b1;
        set_inc_min  = hms_inc_min;
        set_inc_hour = hms_inc_hour;
        if (!hms_set_mode) mode_next = MODE_RUN;
      end
      default: mode_next = MODE_RUN;
    endcase
  end

  logic sec_u_c, sec_roll, min_u_c, min_roll, hour_u_c, hour_t_c;
  logic hour_carry, hour_adv, hour_load, pm_toggle, day_next;
  logic pm, day_pulse;
  bcd_t hour_u_max, hour_t_max;

  // Hour carries only come from the seconds chain in run mode; set-mode minute wraps stop here.
  assign hour_carry = min_roll && (mode == MODE_RUN);
  assign hour_adv   = hour_carry || set_inc_hour;

  always_comb begin
    hour_u_max = HOUR_U_MAX;
    hour_t_max = HOUR_T_MAX_12;
    hour_load  = 1'b0;
    pm_toggle  = 1'b0;
    day_next   = 1'b0;
    if (H24 != 0) begin
      hour_u_max = (hms_hour_t == 4'd2) ? HOUR_U_MAX_24_HI : HOUR_U_MAX;
      hour_t_max = HOUR_T_MAX_24;
      day_next   = hour_carry && hour_t_c;
    end else begin
      hour_load = hour_adv && (hms_hour_t == 4'd1) && (hms_hour_u == 4'd2);
      pm_toggle = hour_adv && (hms_hour_t == 4'd1) && (hms_hour_u == 4'd1);
      day_next  = hour_carry && pm && (hms_hour_t == 4'd1) && (hms_hour_u == 4'd1);
    end
  end

  always_ff @(posedge hms_clock) begin
    if (hms_reset) begin
      pm        <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= day_next;
      if (pm_toggle) pm <= ~pm;
    end
  end

  assign hms_pm        = pm;
  assign hms_day_pulse = day_pulse;

  bcd_digit_counter #(.RST_VAL(4'd0)) u_sec_u (
    .clk(hms_clock), .rst(hms_reset), .en(run_tick), .max(SEC_U_MAX),
    .clear(sec_clear), .load(1'b0), .load_val(4'd0),
    .digit(hms_sec_u), .carry(sec_u_c)
  );

  bcd_digit_counter #(.RST_VAL(4'd0)) u_sec_t (
    .clk(hms_clock), .rst(hms_reset), .en(sec_u_c), .max(SEC_T_MAX),
    .clear(sec_clear), .load(1'b0), .load_val(4'd0),
    .digit(hms_sec_t), .carry(sec_roll)
  );

  bcd_digit_counter #(.RST_VAL(4'd0)) u_min_u (
    .clk(hms_clock), .rst(hms_reset), .en(sec_roll || set_inc_min), .max(MIN_U_MAX),
    .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .digit(hms_min_u), .carry(min_u_c)
  );

  bcd_digit_counter #(.RST_VAL(4'd0)) u_min_t (
    .clk(hms_clock), .rst(hms_reset), .en(min_u_c), .max(MIN_T_MAX),
    .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .digit(hms_min_t), .carry(min_roll)
  );

  // 12-hour mode resets to 12 and reloads 01 after 12.
  bcd_digit_counter #(.RST_VAL((H24 != 0) ? 4'd0 : 4'd2)) u_hour_u (
    .clk(hms_clock), .rst(hms_reset), .en(hour_adv), .max(hour_u_max),
    .clear(1'b0), .load(hour_load), .load_val(4'd1),
    .digit(hms_hour_u), .carry(hour_u_c)
  );

  bcd_digit_counter #(.RST_VAL((H24 != 0) ? 4'd0 : 4'd1)) u_hour_t (
    .clk(hms_clock), .rst(hms_reset), .en(hour_u_c), .max(hour_t_max),
    .clear(1'b0), .load(hour_load), .load_val(4'd0),
    .digit(hms_hour_t), .carry(hour_t_c)
  );

`ifdef HMS_ALARM_EN
  logic [6:0] hour_raw, hour_bin, min_bin, hour_nxt, min_nxt;
  logic       alarm_q;

  // Predict the HH:MM being entered on a :59 rollover so the pulse lines up with :00.
  always_comb begin
    hour_raw = bcd2_to_bin(hms_hour_t, hms_hour_u);
    min_bin  = bcd2_to_bin(hms_min_t, hms_min_u);
    hour_bin = hour_raw;
    if (H24 == 0) begin
      if (hour_raw == 7'd12) hour_bin = pm ? 7'd12 : 7'd0;
      else if (pm)           hour_bin = hour_raw + 7'd12;
    end
    min_nxt  = (min_bin == 7'd59) ? 7'd0 : min_bin + 7'd1;
    hour_nxt = hour_bin;
    if (min_bin == 7'd59) hour_nxt = (hour_bin == 7'd23) ? 7'd0 : hour_bin + 7'd1;
  end

  always_ff @(posedge hms_clock) begin
    if (hms_reset) alarm_q <= 1'b0;
    else           alarm_q <= run_tick && sec_roll &&
                              (hour_nxt == {2'b00, hms_alarm_hour}) &&
                              (min_nxt == {1'b0, hms_alarm_min});
  end

  assign hms_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_hms_counter.sv
// Scoreboard bench for hms_counter: one 24h and one 12h instance, directed vectors.
module tb_hms_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst24 = 1'b0, tick24 = 1'b0, set24 = 1'b0, imin24 = 1'b0, ihour24 = 1'b0;
  logic rst12 = 1'b0, tick12 = 1'b0, set12 = 1'b0, imin12 = 1'b0, ihour12 = 1'b0;
  logic [3:0] su24, st24, mu24, mt24, hu24, ht24;
  logic [3:0] su12, st12, mu12, mt12, hu12, ht12;
  logic pm24, pm12, day24, day12;
  logic alarm24, alarm12;

`ifdef HMS_ALARM_EN
  hms_counter #(.H24(1)) dut24 (
    .hms_clock(clk), .hms_reset(rst24), .hms_tick(tick24), .hms_set_mode(set24),
    .hms_inc_min(imin24), .hms_inc_hour(ihour24),
    .hms_sec_u(su24), .hms_sec_t(st24), .hms_min_u(mu24), .hms_min_t(mt24),
    .hms_hour_u(hu24), .hms_hour_t(ht24), .hms_pm(pm24), .hms_day_pulse(day24),
    .hms_alarm_hour(5'd7), .hms_alarm_min(6'd30), .hms_alarm(alarm24)
  );
  hms_counter #(.H24(0)) dut12 (
    .hms_clock(clk), .hms_reset(rst12), .hms_tick(tick12), .hms_set_mode(set12),
    .hms_inc_min(imin12), .hms_inc_hour(ihour12),
    .hms_sec_u(su12), .hms_sec_t(st12), .hms_min_u(mu12), .hms_min_t(mt12),
    .hms_hour_u(hu12), .hms_hour_t(ht12), .hms_pm(pm12), .hms_day_pulse(day12),
    .hms_alarm_hour(5'd31), .hms_alarm_min(6'd63), .hms_alarm(alarm12)
  );
`else
  assign alarm24 = 1'b0;
  assign alarm12 = 1'b0;
  hms_counter #(.H24(1)) dut24 (
    .hms_clock(clk), .hms_reset(rst24), .hms_tick(tick24), .hms_set_mode(set24),
    .hms_inc_min(imin24), .hms_inc_hour(ihour24),
    .hms_sec_u(su24), .hms_sec_t(st24), .hms_min_u(mu24), .hms_min_t(mt24),
    .hms_hour_u(hu24), .hms_hour_t(ht24), .hms_pm(pm24), .hms_day_pulse(day24)
  );
  hms_counter #(.H24(0)) dut12 (
    .hms_clock(clk), .hms_reset(rst12), .hms_tick(tick12), .hms_set_mode(set12),
    .hms_inc_min(imin12), .hms_inc_hour(ihour12),
    .hms_sec_u(su12), .hms_sec_t(st12), .hms_min_u(mu12), .hms_min_t(mt12),
    .hms_hour_u(hu12), .hms_hour_t(ht12), .hms_pm(pm12), .hms_day_pulse(day12)
  );
`endif

  typedef struct {
    int          cyc;
    bit          sel;
    logic [23:0] digits;
    logic        pm;
    logic        day;
    logic        alarm;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // ofs 0: state visible now; ofs 1: state after the next clock edge.
  task automatic expect_t(input int ofs, input bit sel, input int h, input int m, input int s,
                          input bit pm, input bit day, input bit alarm, input string name);
    exp_t e;
    e.cyc    = cyc + ofs;
    e.sel    = sel;
    e.digits = bcd6(h, m, s);
    e.pm     = pm;
    e.day    = day;
    e.alarm  = alarm;
    e.name   = name;
    sb.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle and compares away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      logic [23:0] dg;
      logic        p, d, a, bad;
      cur = sb.pop_front();
      if (cur.sel) begin
        dg = {ht12, hu12, mt12, mu12, st12, su12}; p = pm12; d = day12; a = alarm12;
      end else begin
        dg = {ht24, hu24, mt24, mu24, st24, su24}; p = pm24; d = day24; a = alarm24;
      end
      bad = (dg !== cur.digits) || (p !== cur.pm) || (d !== cur.day);
`ifdef HMS_ALARM_EN
      bad = bad || (a !== cur.alarm);
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s: got time=%h pm=%b day=%b alarm=%b, expected time=%h pm=%b day=%b alarm=%b",
                 cur.name, dg, p, d, a, cur.digits, cur.pm, cur.day, cur.alarm);
      end
    end
  end

  task automatic drive(input bit sel, input bit rst, input bit tick, input bit setm,
                       input bit imin, input bit ihour);
    if (sel) begin
      {rst12, tick12, set12, imin12, ihour12} = {rst, tick, setm, imin, ihour};
      {rst24, tick24, set24, imin24, ihour24} = 5'b0;
    end else begin
      {rst24, tick24, set24, imin24, ihour24} = {rst, tick, setm, imin, ihour};
      {rst12, tick12, set12, imin12, ihour12} = 5'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Enter set mode, apply hour/minute increments, return to run, then tick seconds.
  task automatic setup(input bit sel, input int nh, input int nm, input int ns);
    drive(sel, 0, 0, 1, 0, 0);
    repeat (nh) drive(sel, 0, 0, 1, 0, 1);
    repeat (nm) drive(sel, 0, 0, 1, 1, 0);
    drive(sel, 0, 0, 0, 0, 0);
    repeat (ns) drive(sel, 0, 1, 0, 0, 0);
  endtask

  initial begin
    rst24 = 1'b1;
    rst12 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_t(0, 0, 0, 0, 0, 0, 0, 0, "reset_24h");
    expect_t(0, 1, 12, 0, 0, 0, 0, 0, "reset_12h");

    // seconds count and minute carry
    expect_t(1, 0, 0, 0, 1, 0, 0, 0, "first_tick");
    drive(0, 0, 1, 0, 0, 0);
    repeat (58) drive(0, 0, 1, 0, 0, 0);
    expect_t(0, 0, 0, 0, 59, 0, 0, 0, "59_ticks");
    expect_t(1, 0, 0, 1, 0, 0, 0, 0, "60th_tick");
    drive(0, 0, 1, 0, 0, 0);
    expect_t(1, 0, 0, 1, 0, 0, 0, 0, "hold_no_tick");
    drive(0, 0, 0, 0, 0, 0);

    // 24h day rollover
    drive(0, 1, 0, 0, 0, 0);
    setup(0, 23, 59, 59);
    expect_t(0, 0, 23, 59, 59, 0, 0, 0, "preset_235959");
    expect_t(1, 0, 0, 0, 0, 0, 1, 0, "day_rollover");
    drive(0, 0, 1, 0, 0, 0);
    expect_t(1, 0, 0, 0, 0, 0, 0, 0, "day_pulse_one_cycle");
    drive(0, 0, 0, 0, 0, 0);

    // reset beats a tick at 23:59:59
    setup(0, 23, 59, 59);
    expect_t(0, 0, 23, 59, 59, 0, 0, 0, "preset_again");
    expect_t(1, 0, 0, 0, 0, 0, 0, 0, "reset_over_tick");
    drive(0, 1, 1, 0, 0, 0);
    expect_t(1, 0, 0, 0, 0, 0, 0, 0, "no_late_day_pulse");
    drive(0, 0, 0, 0, 0, 0);
    expect_t(1, 0, 0, 0, 1, 0, 0, 0, "resume_after_reset");
    drive(0, 0, 1, 0, 0, 0);

    // set mode from 10:59:37
    drive(0, 1, 0, 0, 0, 0);
    setup(0, 10, 59, 37);
    expect_t(0, 0, 10, 59, 37, 0, 0, 0, "preset_105937");
    expect_t(1, 0, 10, 59, 0, 0, 0, 0, "enter_set_clears_sec");
    drive(0, 0, 1, 1, 0, 0);
    expect_t(1, 0, 10, 0, 0, 0, 0, 0, "set_min_wrap_no_carry");
    drive(0, 0, 1, 1, 1, 0);
    expect_t(1, 0, 11, 1, 0, 0, 0, 0, "set_min_and_hour");
    drive(0, 0, 1, 1, 1, 1);
    expect_t(1, 0, 11, 1, 0, 0, 0, 0, "set_tick_ignored");
    drive(0, 0, 1, 1, 0, 0);
    expect_t(1, 0, 11, 1, 0, 0, 0, 0, "leave_set");
    drive(0, 0, 0, 0, 0, 0);
    expect_t(1, 0, 11, 1, 1, 0, 0, 0, "run_after_set");
    drive(0, 0, 1, 0, 0, 0);
    expect_t(1, 0, 11, 1, 1, 0, 0, 0, "inc_ignored_in_run");
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 0);
    repeat (12) drive(0, 0, 0, 1, 0, 1);
    expect_t(0, 0, 23, 1, 0, 0, 0, 0, "set_hour_23");
    expect_t(1, 0, 0, 1, 0, 0, 0, 0, "set_hour_wrap_no_day");
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

`ifdef HMS_ALARM_EN
    drive(0, 1, 0, 0, 0, 0);
    setup(0, 7, 29, 59);
    expect_t(0, 0, 7, 29, 59, 0, 0, 0, "alarm_preset");
    expect_t(1, 0, 7, 30, 0, 0, 0, 1, "alarm_fires");
    drive(0, 0, 1, 0, 0, 0);
    expect_t(1, 0, 7, 30, 1, 0, 0, 0, "alarm_one_cycle");
    drive(0, 0, 1, 0, 0, 0);
`endif

    // 12h: AM->PM at noon, 12->01 without toggle, PM->AM day rollover
    setup(1, 11, 59, 59);
    expect_t(0, 1, 11, 59, 59, 0, 0, 0, "12h_115959_am");
    expect_t(1, 1, 12, 0, 0, 1, 0, 0, "12h_noon_pm");
    drive(1, 0, 1, 0, 0, 0);
    setup(1, 0, 59, 59);
    expect_t(0, 1, 12, 59, 59, 1, 0, 0, "12h_125959_pm");
    expect_t(1, 1, 1, 0, 0, 1, 0, 0, "12h_one_pm");
    drive(1, 0, 1, 0, 0, 0);
    setup(1, 10, 59, 59);
    expect_t(0, 1, 11, 59, 59, 1, 0, 0, "12h_115959_pm");
    expect_t(1, 1, 12, 0, 0, 0, 1, 0, "12h_midnight_day");
    drive(1, 0, 1, 0, 0, 0);
    expect_t(1, 1, 12, 0, 0, 0, 0, 0, "12h_day_pulse_one_cycle");
    drive(1, 0, 0, 0, 0, 0);

    repeat (3) drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hms_counter.md
HMS_COUNTER -- requirements
Module: hms_counter

Interface
REQ-001 SHALL have parameter H24, default 1: 1 = 24-hour display 00-23; 0 = 12-hour display 01-12 with AM/PM flag.
REQ-002 SHALL have port hms_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port hms_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port hms_tick, input, 1 bit: one-cycle enable pulse, one per second, from the 1 Hz enable stage.
REQ-005 SHALL have port hms_set_mode, input, 1 bit: level; 1 = time-set mode, 0 = run mode.
REQ-006 SHALL have port hms_inc_min, input, 1 bit: one-cycle pulse; advance minutes while in set mode.
REQ-007 SHALL have port hms_inc_hour, input, 1 bit: one-cycle pulse; advance hours while in set mode.
REQ-008 SHALL have ports hms_sec_u, hms_sec_t, hms_min_u, hms_min_t, hms_hour_u, hms_hour_t, output, 4 bits each: BCD digits.
REQ-009 SHALL have port hms_pm, output, 1 bit: PM flag; held 0 when H24=1.
REQ-010 SHALL have port hms_day_pulse, output, 1 bit: one-cycle pulse on day rollover.

Function
REQ-011 SHALL implement a two-state FSM: MODE_RUN and MODE_SET; MODE_RUN to MODE_SET when hms_set_mode=1, back when 0; transition takes effect on the next edge.
REQ-012 SHALL, in MODE_RUN on hms_tick=1, advance time by one second; all outputs registered; digits change on the edge after the tick (1-cycle latency).
REQ-013 SHALL wrap seconds 59->00 with carry to minutes, minutes 59->00 with carry to hours; digits always valid BCD.
REQ-014 SHALL, with H24=1, wrap hours 23->00 and pulse hms_day_pulse on 23:59:59->00:00:00.
REQ-015 SHALL, with H24=0, step hours 11->12 while toggling hms_pm, 12->01 without toggle; hms_day_pulse fires on 11:59:59 PM->12:00:00 AM.
REQ-016 SHALL, on the edge entering MODE_SET, clear seconds to 00 and hold them there while in MODE_SET; hms_tick is ignored in MODE_SET.
REQ-017 SHALL, in MODE_SET, on hms_inc_min advance minutes with 59->00 wrap and no hour carry; on hms_inc_hour advance hours with the wrap/PM rules of REQ-014/015 and no hms_day_pulse.
REQ-018 SHALL apply hms_inc_min and hms_inc_hour independently when both pulse in the same cycle.
REQ-019 SHALL give hms_set_mode priority over hms_tick in the same cycle: no second advance occurs.
REQ-020 SHALL ignore hms_inc_min and hms_inc_hour in MODE_RUN.

Reset
REQ-021 SHALL, when hms_reset=1, take priority over all inputs on that edge: FSM to MODE_RUN; time 00:00:00 (H24=1) or 12:00:00 AM (H24=0); hms_pm=0; hms_day_pulse=0.
REQ-022 SHALL, on reset asserted mid-carry or mid-set, discard the pending update; counting resumes from the reset value on the first tick after release.

Configuration
REQ-023 SHALL, when macro HMS_ALARM_EN is defined, add inputs hms_alarm_hour (5 bits, binary hour 0-23) and hms_alarm_min (6 bits, binary 0-59), and output hms_alarm (1 bit) that pulses one cycle when time enters HH:MM:00 matching the alarm in MODE_RUN; without the macro these ports and logic do not exist.

Structure
REQ-024 SHALL place bcd_t (4-bit BCD typedef), mode_t enum (MODE_RUN, MODE_SET) and wrap constants in shared package hms_pkg.
REQ-025 SHALL use sub-module bcd_digit_counter (enable in, programmable max, clear, carry out), one instance per digit.

Verification
REQ-026 SHALL cover: reset, then 59 ticks -> 00:00:59; 60th tick -> 00:01:00, one cycle after the tick.
REQ-027 SHALL cover: H24=1, preset 23:59:59, one tick -> 00:00:00, hms_day_pulse high exactly one cycle.
REQ-028 SHALL cover: H24=0, 11:59:59 AM plus tick -> 12:00:00 PM; 12:59:59 PM plus tick -> 01:00:00 PM, no day pulse.
REQ-029 SHALL cover: set mode at 10:59:37, 2 inc_min plus 1 inc_hour in the same cycle as the second inc_min -> 11:01:00, ticks ignored, no hour carry.
REQ-030 SHALL cover: hms_reset asserted in the same cycle as hms_tick at 23:59:59 -> 00:00:00, no day pulse.
REQ-031 SHALL cover, with HMS_ALARM_EN: alarm 07:30, run from 07:29:59 -> hms_alarm one cycle at 07:30:00, none at 07:30:01.
